// File: rtl/i2c_slave_passcode_rx.sv
// Write-only I2C slave: oversampled SCL/SDA decode, passcode check on one register
// and OTP read/write request generation from another once unlocked.
module i2c_slave_passcode_rx #(
  parameter logic [6:0]  ADDR_DEVICE   = 7'h0A,
  parameter logic [7:0]  ADDR_PASSCODE = 8'h05,
  parameter logic [7:0]  ADDR_OTP      = 8'h04,
  parameter logic [47:0] PASSCODE      = 48'h50_48_53_47_4E_58,
  parameter int          SYNC_STAGES   = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i2c_scl,
  input  logic       i2c_sda,
  output logic       sda_oe,
  output logic       reg_wr_en,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       unlocked,
  output logic       pass_fail,
  output logic       otp_rd_req,
  output logic       otp_wr_req
);

  typedef enum logic [2:0] {
    IDLE, DEV_ADDR, ACK_DEV, REG_ADDR, ACK_REG, DATA, ACK_DATA, IGNORE
  } state_t;

  state_t state_r, state_n;

  logic [SYNC_STAGES-1:0] scl_sync_r, sda_sync_r;
  logic        scl_d_r, sda_d_r;
  logic        scl_s, sda_s;
  logic        rise_s, fall_s, start_s, stop_s;
  logic [6:0]  shift_r;
  logic [7:0]  byte_s;
  logic [2:0]  bit_cnt_r;
  logic        last_bit_s, in_byte_s, in_ack_s;
  logic        ack_on_r;
  logic        wr_pend_r;
  logic [47:0] pass_buf_r;
  logic [47:0] pass_shift_s;
  logic [2:0]  pass_cnt_r;

  assign scl_s      = scl_sync_r[SYNC_STAGES-1];
  assign sda_s      = sda_sync_r[SYNC_STAGES-1];
  assign rise_s     = scl_s & ~scl_d_r;
  assign fall_s     = ~scl_s & scl_d_r;
  assign start_s    = scl_s & scl_d_r & sda_d_r & ~sda_s;
  assign stop_s     = scl_s & scl_d_r & ~sda_d_r & sda_s;
  assign byte_s     = {shift_r, sda_s};
  assign last_bit_s = rise_s && (bit_cnt_r == 3'd7);
  assign in_byte_s  = (state_r == DEV_ADDR) || (state_r == REG_ADDR) || (state_r == DATA);
  assign in_ack_s   = (state_r == ACK_DEV) || (state_r == ACK_REG) || (state_r == ACK_DATA);
  assign pass_shift_s = {pass_buf_r[39:0], reg_wdata};

  // Input synchronisers plus the delay stage used for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync_r <= '1;
      sda_sync_r <= '1;
      scl_d_r    <= 1'b1;
      sda_d_r    <= 1'b1;
    end else begin
      scl_sync_r <= {scl_sync_r[SYNC_STAGES-2:0], i2c_scl};
      sda_sync_r <= {sda_sync_r[SYNC_STAGES-2:0], i2c_sda};
      scl_d_r    <= scl_s;
      sda_d_r    <= sda_s;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_n;
    end
  end

  // Next-state logic; STOP and START override whatever the bus was doing.
  always_comb begin
    state_n = state_r;
    if (stop_s) begin
      state_n = IDLE;
    end else if (start_s) begin
      state_n = DEV_ADDR;
    end else begin
      case (state_r)
        DEV_ADDR: begin
          if (last_bit_s) begin
            if ((byte_s[7:1] == ADDR_DEVICE) && (byte_s[0] == 1'b0)) begin
              state_n = ACK_DEV;
            end else begin
              state_n = IGNORE;
            end
          end else begin
            state_n = DEV_ADDR;
          end
        end
        ACK_DEV:  state_n = (fall_s && ack_on_r) ? REG_ADDR : ACK_DEV;
        REG_ADDR: state_n = last_bit_s ? ACK_REG : REG_ADDR;
        ACK_REG:  state_n = (fall_s && ack_on_r) ? DATA : ACK_REG;
        DATA:     state_n = last_bit_s ? ACK_DATA : DATA;
        ACK_DATA: state_n = (fall_s && ack_on_r) ? DATA : ACK_DATA;
        IDLE:     state_n = IDLE;
        IGNORE:   state_n = IGNORE;
        default:  state_n = IDLE;
      endcase
    end
  end

  // Bit shifting, ACK drive, byte delivery and passcode/OTP side effects.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_r    <= 7'd0;
      bit_cnt_r  <= 3'd0;
      ack_on_r   <= 1'b0;
      sda_oe     <= 1'b0;
      wr_pend_r  <= 1'b0;
      reg_wr_en  <= 1'b0;
      reg_addr   <= 8'd0;
      reg_wdata  <= 8'd0;
      pass_buf_r <= 48'd0;
      pass_cnt_r <= 3'd0;
      unlocked   <= 1'b0;
      pass_fail  <= 1'b0;
      otp_rd_req <= 1'b0;
      otp_wr_req <= 1'b0;
    end else begin
      wr_pend_r  <= 1'b0;
      reg_wr_en  <= wr_pend_r;
      pass_fail  <= 1'b0;
      otp_rd_req <= 1'b0;
      otp_wr_req <= 1'b0;
      if (start_s || stop_s) begin
        bit_cnt_r <= 3'd0;
        ack_on_r  <= 1'b0;
        sda_oe    <= 1'b0;
      end else if (in_byte_s && rise_s) begin
        shift_r   <= byte_s[6:0];
        bit_cnt_r <= bit_cnt_r + 3'd1;
        if (last_bit_s && (state_r == REG_ADDR)) begin
          reg_addr <= byte_s;
        end
        if (last_bit_s && (state_r == DATA)) begin
          reg_wdata <= byte_s;
          wr_pend_r <= 1'b1;
        end
      end else if (in_ack_s && fall_s) begin
        // First falling edge starts the ACK, the second one ends it.
        ack_on_r <= ~ack_on_r;
        sda_oe   <= ~ack_on_r;
      end
      if (wr_pend_r) begin
        if ((reg_addr == ADDR_PASSCODE) && !unlocked) begin
          pass_buf_r <= pass_shift_s;
          if (pass_cnt_r == 3'd5) begin
            pass_cnt_r <= 3'd0;
            if (pass_shift_s == PASSCODE) begin
              unlocked <= 1'b1;
            end else begin
              pass_fail <= 1'b1;
            end
          end else begin
            pass_cnt_r <= pass_cnt_r + 3'd1;
          end
        end
        if ((reg_addr == ADDR_OTP) && unlocked) begin
          otp_rd_req <= (reg_wdata == 8'h00);
          otp_wr_req <= (reg_wdata == 8'h11);
        end
      end
    end
  end

endmodule

// File: tb/tb_i2c_slave_passcode_rx.sv
// Scoreboarded random bench for i2c_slave_passcode_rx: a bus-level master drives
// transactions, a passcode/OTP reference model predicts each delivered byte.
module tb_i2c_slave_passcode_rx;

  localparam logic [47:0] PASS = 48'h50_48_53_47_4E_58;
  localparam time Q = 40;
  localparam time H = 80;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       scl = 1'b1;
  logic       sda_m = 1'b1;
  logic       i2c_sda;
  logic       sda_oe, reg_wr_en, unlocked, pass_fail, otp_rd_req, otp_wr_req;
  logic [7:0] reg_addr, reg_wdata;

  assign i2c_sda = sda_m & ~sda_oe;

  i2c_slave_passcode_rx dut (
    .clk(clk), .rst_n(rst_n), .i2c_scl(scl), .i2c_sda(i2c_sda),
    .sda_oe(sda_oe), .reg_wr_en(reg_wr_en), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
    .unlocked(unlocked), .pass_fail(pass_fail),
    .otp_rd_req(otp_rd_req), .otp_wr_req(otp_wr_req)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
    logic       pf;
    logic       rd;
    logic       wr;
    logic       unl;
  } exp_t;

  exp_t       sb_q[$];
  logic [7:0] pc_q[$];
  logic       model_unlocked = 1'b0;
  int         errors = 0;
  int         checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one fully received data byte to register ra.
  task automatic model_byte(input logic [7:0] ra, input logic [7:0] d);
    exp_t e;
    logic [47:0] w;
    e = '0;
    e.addr = ra;
    e.data = d;
    if (ra == 8'h05 && !model_unlocked) begin
      pc_q.push_back(d);
      if (pc_q.size() == 6) begin
        w = 48'd0;
        for (int i = 0; i < 6; i++) w[47 - 8*i -: 8] = pc_q[i];
        if (w == PASS) model_unlocked = 1'b1;
        else e.pf = 1'b1;
        pc_q.delete();
      end
    end else if (ra == 8'h04 && model_unlocked) begin
      e.rd = (d == 8'h00);
      e.wr = (d == 8'h11);
    end
    e.unl = model_unlocked;
    sb_q.push_back(e);
  endtask

  // Monitor: every delivered byte is matched against the oldest prediction.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (reg_wr_en) begin
        if (sb_q.size() == 0) begin
          check("unexpected_wr", {reg_addr, reg_wdata}, 64'd0);
        end else begin
          e = sb_q.pop_front();
          check("wr_addr", reg_addr, e.addr);
          check("wr_data", reg_wdata, e.data);
          check("pass_fail", pass_fail, e.pf);
          check("otp_rd", otp_rd_req, e.rd);
          check("otp_wr", otp_wr_req, e.wr);
          check("unlocked_at_wr", unlocked, e.unl);
        end
      end else if (pass_fail || otp_rd_req || otp_wr_req) begin
        check("stray_pulse", {pass_fail, otp_rd_req, otp_wr_req}, 64'd0);
      end
    end
  end

  task automatic bit_out(input logic b);
    sda_m = b; #Q; scl = 1'b1; #H; scl = 1'b0; #Q;
  endtask

  task automatic start_c;
    sda_m = 1'b1; #Q; scl = 1'b1; #H; sda_m = 1'b0; #H; scl = 1'b0; #Q;
  endtask

  task automatic stop_c;
    sda_m = 1'b0; #Q; scl = 1'b1; #H; sda_m = 1'b1; #H;
  endtask

  task automatic byte_out(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) bit_out(b[i]);
    sda_m = 1'b1; #Q; scl = 1'b1; #(H/2);
    ack = ~i2c_sda;
    #(H/2); scl = 1'b0; #Q;
  endtask

  task automatic write_n(input logic [7:0] dev, input logic [7:0] ra,
                         input logic [7:0] d [6], input int n);
    logic a;
    logic exp_ack;
    exp_ack = (dev[7:1] == 7'h0A) && !dev[0];
    start_c();
    byte_out(dev, a); check("ack_dev", a, exp_ack);
    byte_out(ra, a);  check("ack_reg", a, exp_ack);
    for (int k = 0; k < n; k++) begin
      if (exp_ack) model_byte(ra, d[k]);
      byte_out(d[k], a); check("ack_data", a, exp_ack);
    end
    stop_c();
    #200;
    check("unlocked_after_txn", unlocked, model_unlocked);
  endtask

  task automatic write1(input logic [7:0] dev, input logic [7:0] ra, input logic [7:0] d);
    logic [7:0] arr [6];
    for (int i = 0; i < 6; i++) arr[i] = d;
    write_n(dev, ra, arr, 1);
  endtask

  task automatic write_partial(input logic [7:0] ra, input logic [7:0] d, input int nbits);
    logic a;
    start_c();
    byte_out(8'h14, a); check("ack_dev_partial", a, 1'b1);
    byte_out(ra, a);    check("ack_reg_partial", a, 1'b1);
    for (int i = 7; i > 7 - nbits; i--) bit_out(d[i]);
    stop_c();
    #200;
  endtask

  task automatic check_reset_state;
    check("rst_sda_oe", sda_oe, 1'b0);
    check("rst_wr_en", reg_wr_en, 1'b0);
    check("rst_addr", reg_addr, 8'd0);
    check("rst_wdata", reg_wdata, 8'd0);
    check("rst_unlocked", unlocked, 1'b0);
    check("rst_pulses", {pass_fail, otp_rd_req, otp_wr_req}, 64'd0);
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    scl = 1'b1;
    sda_m = 1'b1;
    #30;
    check_reset_state();
    model_unlocked = 1'b0;
    pc_q.delete();
    #20;
    rst_n = 1'b1;
    #100;
  endtask

  function automatic logic [7:0] pass_byte(input int idx);
    logic [47:0] p;
    p = PASS;
    return p[47 - 8*idx -: 8];
  endfunction

  task automatic send_passcode(input int from_idx, input int to_idx, input int bad_last);
    for (int i = from_idx; i < to_idx; i++)
      write1(8'h14, 8'h05, (bad_last != 0 && i == 5) ? 8'h59 : pass_byte(i));
  endtask

  initial begin
    logic       a;
    logic [7:0] arr [6];
    logic [7:0] v;
    int         sel;

    #30;
    check_reset_state();
    #20;
    rst_n = 1'b1;
    #100;

    // Correct passcode, then the OTP commands.
    send_passcode(0, 6, 0);
    write1(8'h14, 8'h04, 8'h00);
    write1(8'h14, 8'h04, 8'h11);
    write1(8'h14, 8'h04, 8'h01);
    write1(8'h14, 8'h05, 8'h00);

    // Wrong last byte, then OTP must stay silent.
    do_reset();
    send_passcode(0, 6, 1);
    write1(8'h14, 8'h04, 8'h00);

    // Foreign device and read-direction addresses are ignored.
    write1(8'h16, 8'h05, 8'h50);
    write1(8'h15, 8'h05, 8'h50);

    // Aborted byte leaves the passcode count untouched.
    send_passcode(0, 2, 0);
    write_partial(8'h05, 8'h53, 4);
    send_passcode(2, 6, 0);

    // Reset in the middle of a passcode sequence.
    do_reset();
    send_passcode(0, 3, 0);
    start_c();
    byte_out(8'h14, a);
    byte_out(8'h05, a);
    bit_out(1'b0);
    bit_out(1'b1);
    do_reset();
    send_passcode(3, 6, 0);
    send_passcode(0, 6, 0);

    // Multi-byte write repeats the register address.
    do_reset();
    for (int i = 0; i < 6; i++) arr[i] = pass_byte(i);
    write_n(8'h14, 8'h05, arr, 6);
    arr[0] = 8'h11; arr[1] = 8'h00; arr[2] = 8'h01;
    write_n(8'h14, 8'h04, arr, 3);

    // Randomized traffic.
    do_reset();
    for (int it = 0; it < 40; it++) begin
      sel = $urandom_range(0, 9);
      case (sel)
        0: do_reset();
        1, 2, 3: begin
          v = ($urandom_range(0, 4) == 0) ? 8'($urandom) : pass_byte(pc_q.size());
          write1(8'h14, 8'h05, v);
        end
        4, 5: begin
          case ($urandom_range(0, 3))
            0: v = 8'h00;
            1: v = 8'h11;
            2: v = 8'h01;
            default: v = 8'($urandom);
          endcase
          write1(8'h14, 8'h04, v);
        end
        6: write1(8'h14, 8'($urandom), 8'($urandom));
        7: begin
          v = 8'($urandom);
          if (v == 8'h14) v = 8'h15;
          write1(v, 8'h05, pass_byte(0));
        end
        8: write_partial(8'h05, 8'($urandom), $urandom_range(1, 7));
        default: begin
          for (int i = 0; i < 6; i++) arr[i] = 8'($urandom);
          write_n(8'h14, ($urandom_range(0, 1) != 0) ? 8'h04 : 8'h05, arr, $urandom_range(2, 4));
        end
      endcase
    end

    #500;
    check("scoreboard_empty", sb_q.size(), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
